// File: rtl/wall_query_arbiter.sv
// wall_query_arbiter: round-robin share of the wall-mask read port; req/req_tile_x/req_tile_y in, grant/rsp_valid/rsp_wall out, mask_rd_* to the store
module wall_query_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int TILE_W  = 7,
  parameter int MIN_X   = 0,
  parameter int MAX_X   = 39,
  parameter int MIN_Y   = 0,
  parameter int MAX_Y   = 29
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TILE_W-1:0] req_tile_x,
  input  logic [NUM_REQ*TILE_W-1:0] req_tile_y,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_wall,
  output logic                      mask_rd_en,
  output logic [TILE_W-1:0]         mask_rd_x,
  output logic [TILE_W-1:0]         mask_rd_y,
  input  logic                      mask_rd_data
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, READ, CAPT, RESP} state_t;
  state_t              r_state, w_next;
  logic [PW-1:0]       r_rr, r_win, w_win;
  logic [NUM_REQ-1:0]  r_grant, r_rsp_valid;
  logic [TILE_W-1:0]   r_x, r_y, w_x, w_y;
  logic                r_in, w_in, r_rsp_wall, w_found;
  int                  w_idx;
  logic [TILE_W-1:0]   w_xs [NUM_REQ];
  logic [TILE_W-1:0]   w_ys [NUM_REQ];
  genvar i;
  for (i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_xs[i] = req_tile_x[i*TILE_W +: TILE_W];
    assign w_ys[i] = req_tile_y[i*TILE_W +: TILE_W];
  end
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr) + k;
      w_idx = (w_idx >= NUM_REQ) ? w_idx - NUM_REQ : w_idx;
      if (!w_found && req[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end
  assign w_x  = w_xs[w_win];
  assign w_y  = w_ys[w_win];
  assign w_in = int'(w_x) >= MIN_X && int'(w_x) <= MAX_X && int'(w_y) >= MIN_Y && int'(w_y) <= MAX_Y;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_found ? READ : IDLE) :
             (r_state == READ) ? CAPT :
             (r_state == CAPT) ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      r_win       <= '0;
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_rsp_wall  <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_in        <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= (r_state == CAPT) ? r_grant : '0;
      if (r_state == IDLE && w_found) begin
        r_win   <= w_win;
        r_grant <= NUM_REQ'(1) << w_win;
        r_x     <= w_x;
        r_y     <= w_y;
        r_in    <= w_in;
      end
      if (r_state == CAPT) r_rsp_wall <= r_in ? mask_rd_data : 1'b1;
      if (r_state == RESP) begin
        r_rr    <= (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
        r_grant <= '0;
      end
    end
  end
  assign grant      = r_grant;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_wall   = r_rsp_wall;
  assign mask_rd_en = (r_state == READ) && r_in;
  assign mask_rd_x  = (r_state == IDLE) ? '0 : r_x;
  assign mask_rd_y  = (r_state == IDLE) ? '0 : r_y;
endmodule

// File: tb/tb_wall_query_arbiter.sv
// tb_wall_query_arbiter: scoreboard bench for wall_query_arbiter with a one-cycle-latency wall store model
module tb_wall_query_arbiter;
  localparam int N = 5;
  localparam int W = 7;
  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   rx, ry;
  logic [N-1:0]     grant, rsp_valid;
  logic             rsp_wall, mask_rd_en, mask_rd_data;
  logic [W-1:0]     mask_rd_x, mask_rd_y;
  logic [5:0]       exp_q[$], obs_q[$];
  int               obs_cyc[$];
  logic [5:0]       o, e;
  int               cyc = 0, rd_cnt = 0, errors = 0, checks = 0, rd0 = 0;

  wall_query_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_tile_x(rx), .req_tile_y(ry),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_wall(rsp_wall),
    .mask_rd_en(mask_rd_en), .mask_rd_x(mask_rd_x), .mask_rd_y(mask_rd_y),
    .mask_rd_data(mask_rd_data)
  );

  function automatic logic fw(int x, int y);
    return (x > 39 || y > 29) ? 1'b1 : (((x ^ y) & 1) != 0);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mask_rd_data <= mask_rd_en ? fw(int'(mask_rd_x), int'(mask_rd_y)) : 1'($urandom);
  always @(negedge clk) begin
    if (mask_rd_en) rd_cnt <= rd_cnt + 1;
    if (|rsp_valid) begin
      obs_q.push_back({rsp_valid, rsp_wall});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic wait_obs(input int k);
    int t = 0;
    while (obs_q.size() < k && t < 80) begin
      @(posedge clk);
      t++;
    end
  endtask

  task automatic set_tile(input int r, input int x, input int y);
    rx[r*W +: W] = W'(x);
    ry[r*W +: W] = W'(y);
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; rx = '0; ry = '0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 5'b0) begin errors++; $display("FAIL reset_grant: got %b want 00000", grant); end
    checks++; if (rsp_valid !== 5'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00000", rsp_valid); end
    checks++; if (rsp_wall !== 1'b0) begin errors++; $display("FAIL reset_rsp_wall: got %b want 0", rsp_wall); end
    checks++; if ({mask_rd_en, mask_rd_x, mask_rd_y} !== 15'b0) begin errors++; $display("FAIL reset_mask: got en=%b x=%0d y=%0d want 0", mask_rd_en, mask_rd_x, mask_rd_y); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    req = 5'b00001; set_tile(0, 3, 2); rd0 = rd_cnt;
    exp_q.push_back({5'b00001, 1'b1});
    @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL single_grant: got %b want 00001", grant); end
    checks++; if ({mask_rd_en, mask_rd_x, mask_rd_y} !== {1'b1, 7'd3, 7'd2}) begin errors++; $display("FAIL single_read: got en=%b x=%0d y=%0d want en=1 x=3 y=2", mask_rd_en, mask_rd_x, mask_rd_y); end
    checks++; if (rsp_valid !== 5'b0) begin errors++; $display("FAIL single_early1: got %b want 00000", rsp_valid); end
    @(negedge clk);
    checks++; if ({rsp_valid, mask_rd_en} !== 6'b0) begin errors++; $display("FAIL single_capt: got rsp_valid=%b en=%b want 0", rsp_valid, mask_rd_en); end
    @(negedge clk);
    checks++; if (rsp_valid !== 5'b00001) begin errors++; $display("FAIL single_latency: got %b want 00001", rsp_valid); end
    req = '0;
    @(negedge clk);
    checks++; if ({rsp_valid, grant} !== 10'b0) begin errors++; $display("FAIL single_end: got rsp_valid=%b grant=%b want 0", rsp_valid, grant); end
    checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt - rd0); end
    for (int i = 0; i < 1; i++) begin
      o = 6'bx; if (obs_q.size() != 0) o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_rsp: got %b want %b", o, e); end
    end
  endtask

  task automatic test_out_of_range;
    @(negedge clk);
    req = 5'b00100; set_tile(2, 40, 5); rd0 = rd_cnt;
    exp_q.push_back({5'b00100, 1'b1});
    wait_obs(1);
    @(negedge clk);
    req = '0;
    checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL oor_rd_count: got %0d want 0", rd_cnt - rd0); end
    @(negedge clk);
    req = 5'b00100; set_tile(2, 0, 0); rd0 = rd_cnt;
    exp_q.push_back({5'b00100, 1'b0});
    wait_obs(2);
    @(negedge clk);
    req = '0;
    checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL origin_rd_count: got %0d want 1", rd_cnt - rd0); end
    for (int i = 0; i < 2; i++) begin
      o = 6'bx; if (obs_q.size() != 0) o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL oor_rsp%0d: got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_round_robin;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    obs_cyc.delete();
    for (int i = 0; i < N; i++) set_tile(i, i, 1);
    req = 5'b11111;
    for (int i = 0; i < 6; i++) exp_q.push_back({5'(1 << (i % N)), fw(i % N, 1)});
    wait_obs(6);
    @(negedge clk);
    req = '0;
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (obs_cyc.size() <= i || obs_cyc[i] - obs_cyc[i-1] !== 4) begin
        errors++; $display("FAIL rr_gap%0d: got %0d want 4", i, (obs_cyc.size() > i) ? obs_cyc[i] - obs_cyc[i-1] : -1);
      end
    end
    for (int i = 0; i < 6; i++) begin
      o = 6'bx; if (obs_q.size() != 0) o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rr_rsp%0d: got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_priority_rotation;
    @(negedge clk);
    req = 5'b01000; set_tile(3, 7, 3);
    exp_q.push_back({5'b01000, fw(7, 3)});
    wait_obs(1);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 5'b10010; set_tile(1, 2, 2); set_tile(4, 10, 29);
    exp_q.push_back({5'b10000, fw(10, 29)});
    exp_q.push_back({5'b00010, fw(2, 2)});
    wait_obs(2);
    @(negedge clk);
    req[4] = 1'b0;
    wait_obs(3);
    @(negedge clk);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      o = 6'bx; if (obs_q.size() != 0) o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL prio_rsp%0d: got %b want %b", i, o, e); end
    end
  endtask

  task automatic test_coord_stability;
    @(negedge clk);
    req = 5'b00010; set_tile(1, 5, 2);
    exp_q.push_back({5'b00010, fw(5, 2)});
    @(posedge clk);
    @(negedge clk);
    checks++; if ({mask_rd_x, mask_rd_y} !== {7'd5, 7'd2}) begin errors++; $display("FAIL stab_read: got x=%0d y=%0d want x=5 y=2", mask_rd_x, mask_rd_y); end
    set_tile(1, 6, 2);
    @(negedge clk);
    checks++; if (mask_rd_x !== 7'd5) begin errors++; $display("FAIL stab_capt_x: got %0d want 5", mask_rd_x); end
    wait_obs(1);
    @(negedge clk);
    req = '0;
    for (int i = 0; i < 1; i++) begin
      o = 6'bx; if (obs_q.size() != 0) o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stab_rsp: got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid_query;
    @(negedge clk);
    req = 5'b01000; set_tile(3, 4, 4); set_tile(0, 1, 4);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({grant, rsp_valid} !== 10'b0) begin errors++; $display("FAIL midrst_gv: got grant=%b rsp_valid=%b want 0", grant, rsp_valid); end
    checks++; if ({rsp_wall, mask_rd_en, mask_rd_x, mask_rd_y} !== 16'b0) begin errors++; $display("FAIL midrst_out: got wall=%b en=%b x=%0d y=%0d want 0", rsp_wall, mask_rd_en, mask_rd_x, mask_rd_y); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d responses want 0", obs_q.size()); end
    reset = 1'b0;
    req = 5'b01001;
    exp_q.push_back({5'b00001, fw(1, 4)});
    exp_q.push_back({5'b01000, fw(4, 4)});
    wait_obs(1);
    @(negedge clk);
    req[0] = 1'b0;
    wait_obs(2);
    @(negedge clk);
    req = '0;
    for (int i = 0; i < 2; i++) begin
      o = 6'bx; if (obs_q.size() != 0) o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL midrst_rsp%0d: got %b want %b", i, o, e); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_out_of_range;
    test_round_robin;
    test_priority_rotation;
    test_coord_stability;
    test_reset_mid_query;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wall_query_arbiter.md
# wall_query_arbiter

Round-robin arbiter that shares the single read port of the maze wall-mask store between up to NUM_REQ movers (Pac-Man, ghosts) asking "is tile (x,y) a wall?". Sits between the movement controllers and the wall-mask lookup that also drives the wall renderer's tile map. It serialises queries, runs the one-cycle-latency mask read, clamps out-of-maze coordinates to "wall", and returns a registered per-requester answer.

## Interface
- NUM_REQ, 5, number of requesters (2..8)
- TILE_W, 7, tile coordinate width
- MIN_X, 0, first valid maze tile column
- MAX_X, 39, last valid maze tile column
- MIN_Y, 0, first valid maze tile row
- MAX_Y, 29, last valid maze tile row

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester query request; level, held until matching rsp_valid
- req_tile_x  in  NUM_REQ*TILE_W  packed tile columns; slice i belongs to requester i; held stable while req[i]=1
- req_tile_y  in  NUM_REQ*TILE_W  packed tile rows; same packing as req_tile_x
- grant  out  NUM_REQ  one-hot; the requester currently being served; zero when idle
- rsp_valid  out  NUM_REQ  one-cycle pulse to the served requester; answer is ready
- rsp_wall  out  1  answer; 1 = wall or out of maze; valid while any rsp_valid bit is 1, then held
- mask_rd_en  out  1  read strobe to wall-mask store
- mask_rd_x  out  TILE_W  tile column to read
- mask_rd_y  out  TILE_W  tile row to read
- mask_rd_data  in  1  wall bit; valid exactly one cycle after mask_rd_en

## Operation
- FSM states: IDLE, READ, CAPT, RESP.
- IDLE: if any req bit is 1, select winner by round-robin starting at index rr_ptr (inclusive, increasing, wrapping NUM_REQ-1 -> 0); register winner index, one-hot grant, and its x/y; compute in_range = MIN_X<=x<=MAX_X and MIN_Y<=y<=MAX_Y; go to READ. No req: stay IDLE, grant=0.
- READ: mask_rd_en = in_range; mask_rd_x/y = registered coords (driven whenever not IDLE, zero in IDLE). Go to CAPT.
- CAPT: rsp_wall_next = in_range ? mask_rd_data : 1; register it. Go to RESP.
- RESP: rsp_valid[winner]=1 for exactly this cycle; rr_ptr <= winner+1 (mod NUM_REQ); grant cleared on exit; go to IDLE.
- rr_ptr update only in RESP; a requester just served has lowest priority next arbitration.
- Coordinates are sampled once in IDLE; changes afterward do not affect the in-flight query.
- A requester dropping req mid-query does not abort it; the response still pulses and is ignored.
- Requester must deassert req the cycle after its rsp_valid or be re-queued (re-arbitrated normally from IDLE).
- Arithmetic: range compare unsigned, TILE_W bits; rr_ptr width clog2(NUM_REQ); wrap uses explicit compare, not power-of-two overflow.
- Inputs beyond NUM_REQ-1 do not exist; no X/Z propagation from unused slices.

## Timing
- Reset: state=IDLE, grant=0, rsp_valid=0, rsp_wall=0, mask_rd_en=0, mask_rd_x=0, mask_rd_y=0, rr_ptr=0. Reset mid-query aborts it with no rsp_valid.
- Query sampled in IDLE at edge T: grant visible T+1 (READ, mask_rd_en=1), mask_rd_data sampled T+2 (CAPT), rsp_valid high T+3..T+4.
- Fixed latency: 3 cycles from winning edge to rsp_valid; 4 cycles per query; max throughput one query per 4 cycles.
- grant high in READ, CAPT, RESP (3 cycles).
- Worst-case wait for requester with req held: NUM_REQ*4 cycles + 4.
- Out-of-range queries take identical latency; mask_rd_en stays 0 for them.

## Test plan
- Single query: reset, req[0]=1, x=3,y=2, store returns 1 -> mask_rd_en one pulse at (3,2), rsp_valid=5'b00001 exactly 3 cycles after sampling edge, rsp_wall=1.
- Out of range: req[2]=1, x=40,y=5 -> mask_rd_en never asserted, rsp_valid[2] pulse, rsp_wall=1; then x=0,y=0 with data 0 -> rsp_wall=0.
- Round robin: all five req held continuously -> grant order 0,1,2,3,4,0 with responses every 4 cycles; no requester starved.
- Priority rotation: after serving 3, req[1] and req[4] simultaneous -> 4 served first, then 1.
- Coordinate stability: requester changes x during READ -> mask_rd_x keeps sampled value; response matches original tile.
- Reset mid-query: reset asserted in CAPT -> next cycle all outputs zero, no rsp_valid, rr_ptr=0; next query from req[3] with req[0] also set -> 0 served first.
